// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: opcode encoding, scheduler FSM states and opcode helpers.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [2:0] {
    StIdle,
    StBusy,
    StNop,
    StAluRst,
    StResp
  } sched_state_t;

  // Encodings with no ALU meaning; answered with an error and never forwarded.
  localparam logic [2:0] IllegalOp5 = 3'b101;
  localparam logic [2:0] IllegalOp6 = 3'b110;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
  endfunction

endpackage

// File: rtl/tinyalu_rr_arb.sv
// Round-robin arbiter: one-hot grant searched upward from a registered pointer.
module tinyalu_rr_arb #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              gnt_en_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic [IdxW-1:0]   ptr_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = (32'(ptr_q) + i) % NumReq;
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_idx_o = IdxW'(idx);
      end
    end
    if (found && gnt_en_i) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found && gnt_en_i) begin
      ptr_d = IdxW'((32'(gnt_idx_o) + 1) % NumReq);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/tinyalu_scheduler.sv
// Shares one TinyALU among NumReq requesters: round-robin accept, start/done handshake,
// watchdog abort with ALU reset, and one-hot response back to the winner.
module tinyalu_scheduler
  import tinyalu_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned Timeout   = 16,
  parameter int unsigned RstCycles = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  input  logic [NumReq-1:0][7:0] req_a_i,
  input  logic [NumReq-1:0][7:0] req_b_i,
  input  logic [NumReq-1:0][2:0] req_op_i,
  output logic [NumReq-1:0]      req_ready_o,
  output logic [NumReq-1:0]      rsp_valid_o,
  output logic [15:0]            rsp_result_o,
  output logic                   rsp_error_o,
  output logic [7:0]             alu_a_o,
  output logic [7:0]             alu_b_o,
  output logic [2:0]             alu_op_o,
  output logic                   alu_start_o,
  output logic                   alu_reset_no,
  input  logic                   alu_done_i,
  input  logic [15:0]            alu_result_i
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned WdW  = $clog2(Timeout + 1);
  localparam int unsigned RcW  = $clog2(RstCycles + 1);

  sched_state_t    state_q, state_d;
  logic [IdxW-1:0] widx_q, widx_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic            alu_start_q, alu_start_d;
  logic            alu_rst_n_q, alu_rst_n_d;
  logic [15:0]     result_q, result_d;
  logic            err_q, err_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic [RcW-1:0]  rc_q, rc_d;

  logic [NumReq-1:0] gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic [IdxW-1:0]   rr_ptr;
  logic              gnt_en;
  logic [2:0]        op_sel;

  // alu_rst_n_q is low only in reset and ALURST, so it also blocks a grant in the
  // first cycle after reset release.
  assign gnt_en = (state_q == StIdle) && alu_rst_n_q;

  tinyalu_rr_arb #(
    .NumReq(NumReq)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_valid_i),
    .gnt_en_i (gnt_en),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .ptr_o    (rr_ptr)
  );

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_start_d = alu_start_q;
    alu_rst_n_d = alu_rst_n_q;
    result_d    = result_q;
    err_d       = err_q;
    wd_d        = wd_q;
    rc_d        = rc_q;
    op_sel      = req_op_i[gnt_idx];

    unique case (state_q)
      StIdle: begin
        alu_rst_n_d = 1'b1;
        if (|gnt) begin
          widx_d   = gnt_idx;
          result_d = '0;
          err_d    = 1'b0;
          if (is_alu_op(op_sel)) begin
            alu_a_d     = req_a_i[gnt_idx];
            alu_b_d     = req_b_i[gnt_idx];
            alu_op_d    = op_sel;
            alu_start_d = 1'b1;
            wd_d        = '0;
            state_d     = StBusy;
          end else if (op_sel == no_op) begin
            alu_a_d     = req_a_i[gnt_idx];
            alu_b_d     = req_b_i[gnt_idx];
            alu_op_d    = op_sel;
            alu_start_d = 1'b1;
            state_d     = StNop;
          end else if (op_sel == rst_op) begin
            alu_rst_n_d = 1'b0;
            rc_d        = '0;
            state_d     = StAluRst;
          end else begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StBusy: begin
        if (alu_done_i) begin
          result_d    = alu_result_i;
          alu_start_d = 1'b0;
          state_d     = StResp;
        end else if (wd_q == WdW'(Timeout - 1)) begin
          alu_start_d = 1'b0;
          err_d       = 1'b1;
          alu_rst_n_d = 1'b0;
          rc_d        = '0;
          state_d     = StAluRst;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StNop: begin
        alu_start_d = 1'b0;
        state_d     = StResp;
      end
      StAluRst: begin
        if (rc_q == RcW'(RstCycles - 1)) begin
          alu_rst_n_d = 1'b1;
          state_d     = StResp;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      widx_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= no_op;
      alu_start_q <= 1'b0;
      alu_rst_n_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      wd_q        <= '0;
      rc_q        <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_start_q <= alu_start_d;
      alu_rst_n_q <= alu_rst_n_d;
      result_q    <= result_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
      rc_q        <= rc_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == StResp) begin
      rsp_valid_o[widx_q] = 1'b1;
    end
  end

  assign req_ready_o  = gnt;
  assign rsp_result_o = result_q;
  assign rsp_error_o  = err_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign alu_start_o  = alu_start_q;
  assign alu_reset_no = alu_rst_n_q;

endmodule

// File: tb/tb_tinyalu_scheduler.sv
// Directed bench for tinyalu_scheduler with a stub ALU (1-cycle logic ops, 3-cycle mul).
module tb_tinyalu_scheduler;
  import tinyalu_pkg::*;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [3:0][7:0] req_a;
  logic [3:0][7:0] req_b;
  logic [3:0][2:0] req_op;
  logic [3:0]      req_ready;
  logic [3:0]      rsp_valid;
  logic [15:0]     rsp_result;
  logic            rsp_error;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [2:0]      alu_op;
  logic            alu_start;
  logic            alu_reset_n;
  logic            alu_done;
  logic [15:0]     alu_result;

  logic            hang;
  int unsigned     stub_cnt;
  int              nchk;
  int              npass;
  int              nfail;

  tinyalu_scheduler #(
    .NumReq   (4),
    .Timeout  (16),
    .RstCycles(2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_op_i    (req_op),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_result_o(rsp_result),
    .rsp_error_o (rsp_error),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_start_o (alu_start),
    .alu_reset_no(alu_reset_n),
    .alu_done_i  (alu_done),
    .alu_result_i(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU: counts cycles of alu_start, raises done after the op's latency.
  always @(posedge clk) begin
    if (!alu_start) stub_cnt <= 0;
    else            stub_cnt <= stub_cnt + 1;
  end

  always_comb begin
    alu_done = alu_start && !hang && (stub_cnt == ((alu_op == mul_op) ? 2 : 0));
    case (alu_op)
      add_op:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
      and_op:  alu_result = {8'h00, alu_a & alu_b};
      xor_op:  alu_result = {8'h00, alu_a ^ alu_b};
      mul_op:  alu_result = {8'h00, alu_a} * {8'h00, alu_b};
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"},  32'(req_ready),   32'h0);
    chk({tag, "_rspv"},   32'(rsp_valid),   32'h0);
    chk({tag, "_result"}, 32'(rsp_result),  32'h0);
    chk({tag, "_error"},  32'(rsp_error),   32'h0);
    chk({tag, "_alu_a"},  32'(alu_a),       32'h0);
    chk({tag, "_alu_b"},  32'(alu_b),       32'h0);
    chk({tag, "_alu_op"}, 32'(alu_op),      32'h0);
    chk({tag, "_start"},  32'(alu_start),   32'h0);
    chk({tag, "_alurst"}, 32'(alu_reset_n), 32'h0);
  endtask

  // One request from requester r; response expected in cycle lat (accept cycle = 0).
  task automatic run_op(input string tag, input int r, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input int lat, input logic [15:0] exp_res,
                        input logic exp_err, output int starts, output int rstlow);
    logic early;
    @(negedge clk);
    req_a[r] = a; req_b[r] = b; req_op[r] = op; req_valid[r] = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << r));
    starts = 0; rstlow = 0; early = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) req_valid[r] = 1'b0;
      #1;
      if (alu_start) starts++;
      if (!alu_reset_n) rstlow++;
      if (c < lat && rsp_valid != 4'b0000) early = 1'b1;
    end
    chk({tag, "_early"},  32'(early),      32'h0);
    chk({tag, "_rspv"},   32'(rsp_valid),  32'(4'b0001 << r));
    chk({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
    chk({tag, "_error"},  32'(rsp_error),  32'(exp_err));
  endtask

  logic [15:0] rr_sum [5];
  int          rr_ord [5];
  int          starts, rstlow;
  logic        seen;

  initial begin
    nchk = 0; npass = 0; nfail = 0;
    hang = 1'b0;
    rst_n = 1'b0;
    req_valid = 4'b0000; req_a = '0; req_b = '0; req_op = '0;

    // Reset values, with requests present to show ready stays low
    #12;
    req_valid = 4'b1111;
    #1;
    chk_reset_outs("reset");
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_release_alurst", 32'(alu_reset_n), 32'h1);

    // Round-robin: all four hold add_op
    req_a = {8'hF0, 8'h80, 8'h10, 8'h01};
    req_b = {8'h0F, 8'h90, 8'h20, 8'h02};
    req_op = {add_op, add_op, add_op, add_op};
    rr_ord = '{0, 1, 2, 3, 0};
    rr_sum = '{16'h0003, 16'h0030, 16'h0110, 16'h00FF, 16'h0003};
    @(negedge clk);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk($sformatf("rr%0d_ready", g), 32'(req_ready), 32'(4'b0001 << rr_ord[g]));
      @(negedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_rspv", g),   32'(rsp_valid),  32'(4'b0001 << rr_ord[g]));
      chk($sformatf("rr%0d_result", g), 32'(rsp_result), 32'(rr_sum[g]));
      if (g == 4) req_valid = 4'b0000;
      @(negedge clk);
    end

    // Single add, requester 0
    run_op("add", 0, 8'h12, 8'h34, add_op, 2, 16'h0046, 1'b0, starts, rstlow);
    chk("add_starts", 32'(starts), 32'd1);

    // Mul latency, requester 2
    run_op("mul", 2, 8'hFF, 8'hFF, mul_op, 4, 16'hFE01, 1'b0, starts, rstlow);
    chk("mul_starts", 32'(starts), 32'd3);

    // no_op
    run_op("nop", 1, 8'h55, 8'h66, no_op, 2, 16'h0000, 1'b0, starts, rstlow);
    chk("nop_starts", 32'(starts), 32'd1);

    // rst_op
    run_op("rstop", 3, 8'h00, 8'h00, rst_op, 3, 16'h0000, 1'b0, starts, rstlow);
    chk("rstop_rstlow", 32'(rstlow), 32'd2);
    chk("rstop_starts", 32'(starts), 32'd0);

    // Illegal opcodes
    run_op("ill5", 0, 8'h11, 8'h22, 3'b101, 1, 16'h0000, 1'b1, starts, rstlow);
    chk("ill5_starts", 32'(starts), 32'd0);
    run_op("ill6", 2, 8'h11, 8'h22, 3'b110, 1, 16'h0000, 1'b1, starts, rstlow);
    chk("ill6_starts", 32'(starts), 32'd0);

    // Timeout: stub never raises done
    hang = 1'b1;
    run_op("tmo", 1, 8'hAA, 8'h55, xor_op, 19, 16'h0000, 1'b1, starts, rstlow);
    chk("tmo_starts", 32'(starts), 32'd16);
    chk("tmo_rstlow", 32'(rstlow), 32'd2);
    hang = 1'b0;
    run_op("post_tmo", 2, 8'hAA, 8'h0F, xor_op, 2, 16'h00A5, 1'b0, starts, rstlow);

    // Reset in cycle 2 of a mul from requester 1 (pointer moves to 2)
    @(negedge clk);
    req_a[1] = 8'h10; req_b[1] = 8'h10; req_op[1] = mul_op; req_valid[1] = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    chk("midrst_start", 32'(alu_start), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      #1;
      if (rsp_valid != 4'b0000) seen = 1'b1;
    end
    chk("midrst_norsp", 32'(seen), 32'h0);

    // Requesters 1 and 3 pending: pointer 0 must pick 1 first
    @(negedge clk);
    req_a[1] = 8'h21; req_b[1] = 8'h01; req_op[1] = add_op;
    req_a[3] = 8'h03; req_b[3] = 8'h04; req_op[3] = add_op;
    req_valid = 4'b1010;
    #1;
    chk("after_rst_ready1", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    #1;
    chk("after_rst_rspv1", 32'(rsp_valid), 32'h2);
    chk("after_rst_res1",  32'(rsp_result), 32'h0022);
    @(negedge clk);
    #1;
    chk("after_rst_ready3", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk);
    #1;
    chk("after_rst_rspv3", 32'(rsp_valid), 32'h8);
    chk("after_rst_res3",  32'(rsp_result), 32'h0007);

    @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
